pipe_stage_buf: RTL

//  Generic pipeline stage register with a valid/ready handshake, used between pipeline

---
 rtl/pipe_stage_buf.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// bubble-zeroed control field and a saturating downstream-stall counter.
module pipe_stage_buf #(
  parameter int unsigned DATA_W     = 96,
  parameter int unsigned CTRL_W     = 12,
  parameter int unsigned SKID       = 1,
  parameter int unsigned CLEAR_DATA = 1,
  parameter int unsigned STAT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [STAT_W-1:0] stall_cnt
);

  localparam logic [STAT_W-1:0] STALL_MAX = {STAT_W{1'b1}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                m_valid_q, m_valid_d;
  logic                s_valid_q, s_valid_d;
  logic [CTRL_W-1:0]   m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d, s_data_q, s_data_d;
  logic [1:0]          occ_q, occ_d;
  logic [STAT_W-1:0]   stall_q, stall_d;
  logic                xfer_in, xfer_out;

  // Skid mode registers in_ready off S; single-entry mode lets a release free M in the same cycle.
  assign in_ready = (SKID != 0) ? (!s_valid_q && !flush && !rst)
                                : ((!m_valid_q || out_ready) && !flush && !rst);

  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = m_valid_q && out_ready;

  assign out_valid = m_valid_q;
  assign out_ctrl  = m_ctrl_q;
  assign out_data  = m_data_q;
  assign occupancy = occ_q;
  assign stall_cnt = stall_q;

  // State and payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_ctrl_q  <= '0;
      s_ctrl_q  <= '0;
      m_data_q  <= '0;
      s_data_q  <= '0;
      occ_q     <= 2'd0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_ctrl_q  <= m_ctrl_d;
      s_ctrl_q  <= s_ctrl_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
      occ_q     <= occ_d;
      stall_q   <= stall_d;
    end
  end

  // Next-state and payload movement
  always_comb begin
    state_d  = state_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
    stall_d  = stall_q;

    if (m_valid_q && !out_ready && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + STAT_W'(1);
    end

    if (flush) begin
      state_d  = EMPTY;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
      if (CLEAR_DATA != 0) begin
        m_data_d = '0;
        s_data_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (xfer_in) begin
            state_d  = ONE;
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
          end
        end
        ONE: begin
          if (xfer_in && xfer_out) begin
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
          end else if (xfer_in && (SKID != 0)) begin
            state_d  = FULL;
            s_ctrl_d = in_ctrl;
            s_data_d = in_data;
          end else if (xfer_out) begin
            state_d  = EMPTY;
            m_ctrl_d = '0;
            if (CLEAR_DATA != 0) m_data_d = '0;
          end
        end
        FULL: begin
          if (xfer_out) begin
            state_d  = ONE;
            m_ctrl_d = s_ctrl_q;
            m_data_d = s_data_q;
            s_ctrl_d = '0;
            if (CLEAR_DATA != 0) s_data_d = '0;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end

    m_valid_d = (state_d != EMPTY);
    s_valid_d = (state_d == FULL);
    case (state_d)
      ONE:     occ_d = 2'd1;
      FULL:    occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase
  end

endmodule
